retry_ctrl_flit_sched: RTL and testbench
========================================

# retry_ctrl_flit_sched

Link-layer retry control-flit scheduler for the CXL controller TX path. It shares the single TX control-flit slot between three requesters: the remote retry state machine (RETRY.Ack), the local retry state machine (RETRY.Req) and the credit-return logic (LLCRD). Each RETRY.Req or RETRY.Ack goes out as an atomic sequence of NUM_FRAMES RETRY.Frame flits followed by the control flit. The block returns per-requester "sent" pulses and hands idle slots to the data path.

## Interface
- NUM_FRAMES, default 5: RETRY.Frame flits sent before each RETRY.Req/RETRY.Ack (legal range 1..7).
- i_clk  in  1  sole clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_ack_req  in  1  level from remote retry SM; RETRY.Ack needed.
- i_req_req  in  1  level from local retry SM; RETRY.Req needed.
- i_llcrd_req  in  1  level from credit logic; LLCRD flit needed.
- i_phy_reinit  in  1  PHY re-initialisation; aborts any sequence.
- i_tx_ready  in  1  packer accepts the presented control flit.
- o_flit_valid  out  1  control flit presented.
- o_flit_type  out  3  retry_pkg::ctrl_flit_t: NONE=0, FRAME=1, RETRY_REQ=2, RETRY_ACK=3, LLCRD=4.
- o_ack_sent  out  1  one-cycle pulse: RETRY.Ack accepted.
- o_req_sent  out  1  one-cycle pulse: RETRY.Req accepted.
- o_llcrd_sent  out  1  one-cycle pulse: LLCRD accepted.
- o_data_grant  out  1  slot free for data flits this cycle.

## Operation
- A flit is accepted in a cycle where o_flit_valid && i_tx_ready.
- States (retry_pkg::sched_state_t): IDLE, FRAME, CTRL.
- IDLE: o_flit_valid=0.
  - If ack or req is pending, pick a winner with the 2-way round-robin, load the frame counter with 0 and go to FRAME.
  - If both are pending, the winner is the one not served last.
  - Else, if llcrd is pending, latch sel=LLCRD and go to CTRL.
  - Else o_data_grant=1.
- FRAME: o_flit_valid=1, type FRAME.
  - Each accept increments the counter.
  - Accept with counter==NUM_FRAMES-1 goes to CTRL.
  - The counter width is $clog2(NUM_FRAMES+1) and it never wraps.
- CTRL: o_flit_valid=1, type from latched sel (RETRY_ACK, RETRY_REQ or LLCRD).
  - On accept: pulse the matching *_sent combinationally in the same cycle, update the round-robin pointer (ack/req only) and go to IDLE.
- Sequences are atomic. A new request arriving mid-sequence waits; it never preempts.
- While i_tx_ready=0: o_flit_valid stays high, o_flit_type stays stable, and the state and counter hold.
- i_phy_reinit=1 in any state:
  - o_flit_valid, all *_sent and o_data_grant forced 0 combinationally.
  - Next state is IDLE; the counter is cleared.
  - The round-robin pointer is unchanged.
  - Requests are ignored while i_phy_reinit is high.
- Requesters must drop their level no later than the cycle after the *_sent pulse. A request still high in the next IDLE decision cycle is treated as a new request.
- Reset (i_rst=1 at an edge):
  - State IDLE, counter 0, sel NONE.
  - Round-robin pointer set so ack wins the first tie.
  - All outputs 0 during and after reset until the first IDLE evaluation; o_data_grant may assert the cycle after reset is released.
- Reset mid-sequence discards the sequence with no sent pulse.

## Timing
- Request to first valid: a request seen in IDLE at cycle t gives o_flit_valid=1 at t+1.
- Minimum length of a retry sequence with i_tx_ready held 1: NUM_FRAMES+1 cycles of valid, plus 1 IDLE decision cycle.
- Back-to-back: after CTRL accept at t, IDLE at t+1, next sequence valid at t+2.
- LLCRD with ready held 1: request at t, valid at t+1, o_llcrd_sent at t+1.
- *_sent pulses are exactly 1 cycle wide and coincide with the accepting edge's cycle.
- All outputs are decoded from registered state and sel, except that *_sent depends on i_tx_ready and all outputs are gated by i_phy_reinit.

## Structure
- retry_pkg holds:
  - ctrl_flit_t enum (3 bits);
  - sched_state_t enum;
  - requester index enum REQ_ACK/REQ_REQ/REQ_LLCRD;
  - localparam default NUM_FRAMES=5.
- One sub-module, rr_arb2: two-requester round-robin.
  - Inputs: req[1:0], update, clk, rst.
  - Output: one-hot grant.
  - The pointer advances only on update.
  - It is instantiated for the ack/req pair.
- The top module holds the FSM, frame counter, sel register and output decode.

## Test plan
- Ack only, ready=1, NUM_FRAMES=5 -> valid for 6 cycles: types 1,1,1,1,1,3; o_ack_sent high on cycle 6 only; o_data_grant=0 throughout.
- Ack and req both raised at the same cycle after reset -> ack sequence first, then req sequence starting 2 cycles after o_ack_sent; repeat the tie -> req wins.
- Ready toggles 1,0,0,1 during FRAME -> counter holds on 0 cycles; exactly 5 FRAME accepts before CTRL; o_flit_type stable while stalled.
- i_phy_reinit pulsed on the 3rd FRAME cycle -> valid drops the same cycle; no *_sent; IDLE the next cycle; a held request restarts with a full 5 frames.
- LLCRD raised during an ack sequence -> LLCRD waits; it is sent as a single type-4 flit one IDLE cycle after o_ack_sent.
- i_rst asserted in CTRL with ready=0 -> the next cycle is IDLE with all outputs 0; no sent pulse; the first tie after reset goes to ack.

Source files
------------

// File: rtl/retry_ctrl_flit_sched_pkg.sv
// Shared types for the link-layer retry control-flit scheduler: flit encodings,
// scheduler states and requester indices.
package retry_pkg;

  localparam int DEFAULT_NUM_FRAMES = 5;

  typedef enum logic [2:0] {
    CF_NONE      = 3'd0,
    CF_FRAME     = 3'd1,
    CF_RETRY_REQ = 3'd2,
    CF_RETRY_ACK = 3'd3,
    CF_LLCRD     = 3'd4
  } ctrl_flit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_CTRL
  } sched_state_t;

  typedef enum logic [1:0] {
    REQ_ACK   = 2'd0,
    REQ_REQ   = 2'd1,
    REQ_LLCRD = 2'd2
  } req_idx_t;

  // Control flit that closes out a given requester's transfer.
  function automatic ctrl_flit_t flit_of(req_idx_t r);
    case (r)
      REQ_ACK:   return CF_RETRY_ACK;
      REQ_REQ:   return CF_RETRY_REQ;
      REQ_LLCRD: return CF_LLCRD;
      default:   return CF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/retry_ctrl_flit_sched_if.sv
// Request / control-flit handshake bundle between the retry requesters, the
// TX packer and the scheduler (slave side).
interface retry_ctrl_flit_sched_if;
  import retry_pkg::*;

  logic       i_ack_req;
  logic       i_req_req;
  logic       i_llcrd_req;
  logic       i_phy_reinit;
  logic       i_tx_ready;
  logic       o_flit_valid;
  ctrl_flit_t o_flit_type;
  logic       o_ack_sent;
  logic       o_req_sent;
  logic       o_llcrd_sent;
  logic       o_data_grant;

  modport master (
    output i_ack_req, i_req_req, i_llcrd_req, i_phy_reinit, i_tx_ready,
    input  o_flit_valid, o_flit_type, o_ack_sent, o_req_sent, o_llcrd_sent,
           o_data_grant
  );

  modport slave (
    input  i_ack_req, i_req_req, i_llcrd_req, i_phy_reinit, i_tx_ready,
    output o_flit_valid, o_flit_type, o_ack_sent, o_req_sent, o_llcrd_sent,
           o_data_grant
  );

endinterface

// File: rtl/retry_ctrl_flit_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves only when the
// granted requester's transfer is confirmed via update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prefer_hi;  // 1: req[1] wins a tie

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)         prefer_hi <= 1'b0;
    else if (update) prefer_hi <= grant[0];
  end

  always_comb begin
    grant = req;
    if (&req) grant = prefer_hi ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/retry_ctrl_flit_sched.sv
// Shares the TX control-flit slot between RETRY.Ack, RETRY.Req and LLCRD;
// retry flits go out as atomic NUM_FRAMES x RETRY.Frame + control flit.
module retry_ctrl_flit_sched
  import retry_pkg::*;
#(
  parameter int NUM_FRAMES = DEFAULT_NUM_FRAMES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  retry_ctrl_flit_sched_if.slave  bus
);

  localparam int              CW   = $clog2(NUM_FRAMES + 1);
  localparam logic [CW-1:0]   LAST = CW'(NUM_FRAMES - 1);

  sched_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_flit_t    sel, sel_n;

  logic [1:0] rr_req, rr_grant;
  logic       rr_update;

  logic       flit_valid, ack_sent, req_sent, llcrd_sent, data_grant;
  ctrl_flit_t flit_type;

  // In CTRL the arbiter sees the sequence being closed, so update credits it.
  assign rr_req = (state == ST_CTRL) ? {sel == CF_RETRY_REQ, sel == CF_RETRY_ACK}
                                     : {bus.i_req_req, bus.i_ack_req};

  rr_arb2 u_rr (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (rr_req),
    .update (rr_update),
    .grant  (rr_grant)
  );

  // NOTE: only control state is reset; the output decode is purely combinational.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel   <= CF_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sel_n      = sel;
    flit_valid = 1'b0;
    flit_type  = CF_NONE;
    ack_sent   = 1'b0;
    req_sent   = 1'b0;
    llcrd_sent = 1'b0;
    data_grant = 1'b0;
    rr_update  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rr_grant != 2'b00) begin
          sel_n   = flit_of(rr_grant[1] ? REQ_REQ : REQ_ACK);
          cnt_n   = '0;
          state_n = ST_FRAME;
        end else if (bus.i_llcrd_req) begin
          sel_n   = flit_of(REQ_LLCRD);
          state_n = ST_CTRL;
        end else begin
          data_grant = 1'b1;
        end
      end
      ST_FRAME: begin
        flit_valid = 1'b1;
        flit_type  = CF_FRAME;
        if (bus.i_tx_ready) begin
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) state_n = ST_CTRL;
        end
      end
      ST_CTRL: begin
        flit_valid = 1'b1;
        flit_type  = sel;
        if (bus.i_tx_ready) begin
          ack_sent   = (sel == CF_RETRY_ACK);
          req_sent   = (sel == CF_RETRY_REQ);
          llcrd_sent = (sel == CF_LLCRD);
          rr_update  = (sel == CF_RETRY_ACK) || (sel == CF_RETRY_REQ);
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (bus.i_phy_reinit) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      sel_n   = sel;
    end

    if (bus.i_phy_reinit || i_rst) begin
      flit_valid = 1'b0;
      flit_type  = CF_NONE;
      ack_sent   = 1'b0;
      req_sent   = 1'b0;
      llcrd_sent = 1'b0;
      data_grant = 1'b0;
      rr_update  = 1'b0;
    end
  end

  assign bus.o_flit_valid = flit_valid;
  assign bus.o_flit_type  = flit_type;
  assign bus.o_ack_sent   = ack_sent;
  assign bus.o_req_sent   = req_sent;
  assign bus.o_llcrd_sent = llcrd_sent;
  assign bus.o_data_grant = data_grant;

endmodule

// File: tb/tb_retry_ctrl_flit_sched.sv
// Scenario bench for retry_ctrl_flit_sched: a scoreboard queue holds the flits
// each scenario expects, a negedge monitor pops one per accepted flit.
module tb_retry_ctrl_flit_sched;
  import retry_pkg::*;

  localparam int NF = 5;
  localparam int MAXC = 64;
  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] ZERO = '0;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  ctrl_flit_t exp_q[$];

  logic       obs_valid [MAXC];
  logic       obs_rdy   [MAXC];
  ctrl_flit_t obs_type  [MAXC];
  logic       obs_grant [MAXC];
  logic       obs_ack   [MAXC];
  logic       obs_req   [MAXC];
  logic       obs_llc   [MAXC];

  retry_ctrl_flit_sched_if bus ();

  retry_ctrl_flit_sched #(.NUM_FRAMES(NF)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [2:0] sent_of(ctrl_flit_t t);
    case (t)
      CF_RETRY_ACK: return 3'b100;
      CF_RETRY_REQ: return 3'b010;
      CF_LLCRD:     return 3'b001;
      default:      return 3'b000;
    endcase
  endfunction

  task automatic push_retry(input ctrl_flit_t t);
    for (int i = 0; i < NF; i++) exp_q.push_back(CF_FRAME);
    exp_q.push_back(t);
  endtask

  // Scoreboard consumer: every accepted flit must be the next expected one.
  always @(negedge i_clk) begin
    logic [2:0] sent_obs;
    ctrl_flit_t e;
    sent_obs = {bus.o_ack_sent, bus.o_req_sent, bus.o_llcrd_sent};
    if (!i_rst && bus.o_flit_valid && bus.i_tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_flit: got type %0d, queue empty", bus.o_flit_type);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_flit_type !== e) begin
          errors++;
          $display("FAIL sb_flit_type: got %0d, expected %0d", bus.o_flit_type, e);
        end
        checks++;
        if (sent_obs !== sent_of(e)) begin
          errors++;
          $display("FAIL sb_sent_pulse: got %b, expected %b", sent_obs, sent_of(e));
        end
      end
    end else if (sent_obs !== 3'b000) begin
      checks++;
      errors++;
      $display("FAIL sb_sent_without_accept: got %b, expected 000", sent_obs);
    end
  end

  // Runs n cycles from an IDLE decision cycle (index 0). Masks give per-cycle
  // ready/reinit and request raises; a level drops the cycle after its *_sent.
  task automatic watch(input int n, input logic [63:0] rdy_m, input logic [63:0] reinit_m,
                       input logic [63:0] ack_m, input logic [63:0] req_m,
                       input logic [63:0] llc_m);
    logic da, dr, dl;
    da = 1'b0; dr = 1'b0; dl = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin @(posedge i_clk); #1; end
      if (da) bus.i_ack_req   = 1'b0;
      if (dr) bus.i_req_req   = 1'b0;
      if (dl) bus.i_llcrd_req = 1'b0;
      da = 1'b0; dr = 1'b0; dl = 1'b0;
      bus.i_tx_ready   = rdy_m[c];
      bus.i_phy_reinit = reinit_m[c];
      if (ack_m[c]) bus.i_ack_req   = 1'b1;
      if (req_m[c]) bus.i_req_req   = 1'b1;
      if (llc_m[c]) bus.i_llcrd_req = 1'b1;
      @(negedge i_clk);
      obs_valid[c] = bus.o_flit_valid;
      obs_rdy[c]   = bus.i_tx_ready;
      obs_type[c]  = bus.o_flit_type;
      obs_grant[c] = bus.o_data_grant;
      obs_ack[c]   = bus.o_ack_sent;
      obs_req[c]   = bus.o_req_sent;
      obs_llc[c]   = bus.o_llcrd_sent;
      if (bus.o_ack_sent)   da = 1'b1;
      if (bus.o_req_sent)   dr = 1'b1;
      if (bus.o_llcrd_sent) dl = 1'b1;
    end
    @(posedge i_clk); #1;
    if (da) bus.i_ack_req   = 1'b0;
    if (dr) bus.i_req_req   = 1'b0;
    if (dl) bus.i_llcrd_req = 1'b0;
    bus.i_phy_reinit = 1'b0;
    bus.i_tx_ready   = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    i_rst = 1'b1;
    bus.i_ack_req = 1'b0; bus.i_req_req = 1'b0; bus.i_llcrd_req = 1'b0;
    bus.i_phy_reinit = 1'b0; bus.i_tx_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    outs = {bus.o_flit_valid, bus.o_flit_type, bus.o_ack_sent, bus.o_req_sent,
            bus.o_llcrd_sent, bus.o_data_grant};
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h, expected 00", outs);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_data_grant !== 1'b1 || bus.o_flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: grant=%b valid=%b, expected grant=1 valid=0",
               bus.o_data_grant, bus.o_flit_valid);
    end
    @(posedge i_clk); #1;
  endtask

  // Tie right after reset: ack first, req 2 cycles after o_ack_sent.
  task automatic test_tie_ack_first();
    int nv;
    push_retry(CF_RETRY_ACK);
    push_retry(CF_RETRY_REQ);
    watch(16, ONES, ZERO, 64'h1, 64'h1, ZERO);
    nv = 0;
    for (int c = 1; c <= 13; c++) nv += int'(obs_valid[c]);
    checks++;
    if (obs_ack[6] !== 1'b1 || obs_type[6] !== CF_RETRY_ACK) begin
      errors++; $display("FAIL tie1_ack_first: ack_sent=%b type=%0d at cycle 6, expected 1/3",
                         obs_ack[6], obs_type[6]);
    end
    checks++;
    if (obs_valid[7] !== 1'b0 || obs_valid[8] !== 1'b1) begin
      errors++; $display("FAIL tie1_gap: valid[7]=%b valid[8]=%b, expected 0/1",
                         obs_valid[7], obs_valid[8]);
    end
    checks++;
    if (obs_req[13] !== 1'b1 || obs_type[13] !== CF_RETRY_REQ) begin
      errors++; $display("FAIL tie1_req_second: req_sent=%b type=%0d at cycle 13, expected 1/2",
                         obs_req[13], obs_type[13]);
    end
    checks++;
    if (nv != 12 || obs_grant[14] !== 1'b1) begin
      errors++; $display("FAIL tie1_totals: valid cycles=%0d grant[14]=%b, expected 12/1",
                         nv, obs_grant[14]);
    end
  endtask

  task automatic test_ack_only();
    int nv, ng, na;
    push_retry(CF_RETRY_ACK);
    watch(10, ONES, ZERO, 64'h1, ZERO, ZERO);
    nv = 0; ng = 0; na = 0;
    for (int c = 0; c < 10; c++) begin
      nv += int'(obs_valid[c]);
      ng += int'(obs_grant[c]);
      na += int'(obs_ack[c]);
    end
    checks++;
    if (obs_valid[0] !== 1'b0 || obs_valid[1] !== 1'b1) begin
      errors++; $display("FAIL ack_latency: valid[0]=%b valid[1]=%b, expected 0/1",
                         obs_valid[0], obs_valid[1]);
    end
    checks++;
    if (nv != NF + 1) begin
      errors++; $display("FAIL ack_valid_len: got %0d, expected %0d", nv, NF + 1);
    end
    checks++;
    if (na != 1 || obs_ack[6] !== 1'b1) begin
      errors++; $display("FAIL ack_sent_pulse: count=%0d at6=%b, expected 1/1", na, obs_ack[6]);
    end
    checks++;
    if (ng != 3 || obs_grant[6] !== 1'b0) begin
      errors++; $display("FAIL ack_data_grant: grant cycles=%0d, expected 3 (cycles 7..9)", ng);
    end
  endtask

  // Ack was served last, so a fresh tie goes to req.
  task automatic test_tie_req_wins();
    push_retry(CF_RETRY_REQ);
    push_retry(CF_RETRY_ACK);
    watch(16, ONES, ZERO, 64'h1, 64'h1, ZERO);
    checks++;
    if (obs_req[6] !== 1'b1 || obs_ack[13] !== 1'b1) begin
      errors++; $display("FAIL tie2_req_wins: req_sent[6]=%b ack_sent[13]=%b, expected 1/1",
                         obs_req[6], obs_ack[13]);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rdy;
    int nf;
    rdy = ONES;
    rdy[2] = 1'b0;
    rdy[3] = 1'b0;
    push_retry(CF_RETRY_ACK);
    watch(11, rdy, ZERO, 64'h1, ZERO, ZERO);
    nf = 0;
    for (int c = 1; c <= 7; c++)
      if (obs_valid[c] && obs_rdy[c] && obs_type[c] == CF_FRAME) nf++;
    checks++;
    if (obs_valid[2] !== 1'b1 || obs_type[2] !== CF_FRAME ||
        obs_valid[3] !== 1'b1 || obs_type[3] !== CF_FRAME) begin
      errors++; $display("FAIL stall_hold: v2=%b t2=%0d v3=%b t3=%0d, expected 1/1/1/1",
                         obs_valid[2], obs_type[2], obs_valid[3], obs_type[3]);
    end
    checks++;
    if (nf != NF) begin
      errors++; $display("FAIL stall_frame_accepts: got %0d, expected %0d", nf, NF);
    end
    checks++;
    if (obs_ack[8] !== 1'b1 || obs_type[8] !== CF_RETRY_ACK) begin
      errors++; $display("FAIL stall_ctrl: ack_sent=%b type=%0d at 8, expected 1/3",
                         obs_ack[8], obs_type[8]);
    end
  endtask

  task automatic test_reinit();
    logic [63:0] ri;
    int ns, nf;
    ri = ZERO;
    ri[3] = 1'b1;
    exp_q.push_back(CF_FRAME);
    exp_q.push_back(CF_FRAME);
    push_retry(CF_RETRY_ACK);
    watch(13, ONES, ri, 64'h1, ZERO, ZERO);
    ns = 0; nf = 0;
    for (int c = 0; c <= 9; c++) ns += int'(obs_ack[c]) + int'(obs_req[c]) + int'(obs_llc[c]);
    for (int c = 5; c <= 9; c++) if (obs_valid[c] && obs_type[c] == CF_FRAME) nf++;
    checks++;
    if (obs_valid[3] !== 1'b0 || obs_grant[3] !== 1'b0) begin
      errors++; $display("FAIL reinit_gate: valid=%b grant=%b at 3, expected 0/0",
                         obs_valid[3], obs_grant[3]);
    end
    checks++;
    if (obs_valid[4] !== 1'b0 || ns != 0) begin
      errors++; $display("FAIL reinit_abort: valid[4]=%b early sent=%0d, expected 0/0",
                         obs_valid[4], ns);
    end
    checks++;
    if (nf != NF || obs_ack[10] !== 1'b1) begin
      errors++; $display("FAIL reinit_restart: frames=%0d ack_sent[10]=%b, expected %0d/1",
                         nf, obs_ack[10], NF);
    end
  endtask

  task automatic test_llcrd_wait();
    push_retry(CF_RETRY_ACK);
    exp_q.push_back(CF_LLCRD);
    watch(12, ONES, ZERO, 64'h1, ZERO, 64'h4);
    checks++;
    if (obs_ack[6] !== 1'b1 || obs_valid[7] !== 1'b0) begin
      errors++; $display("FAIL llcrd_waits: ack_sent[6]=%b valid[7]=%b, expected 1/0",
                         obs_ack[6], obs_valid[7]);
    end
    checks++;
    if (obs_llc[8] !== 1'b1 || obs_type[8] !== CF_LLCRD || obs_valid[9] !== 1'b0) begin
      errors++; $display("FAIL llcrd_after_ack: sent=%b type=%0d valid[9]=%b, expected 1/4/0",
                         obs_llc[8], obs_type[8], obs_valid[9]);
    end
  endtask

  task automatic test_llcrd_only();
    exp_q.push_back(CF_LLCRD);
    watch(4, ONES, ZERO, ZERO, ZERO, 64'h1);
    checks++;
    if (obs_valid[1] !== 1'b1 || obs_llc[1] !== 1'b1 || obs_grant[2] !== 1'b1) begin
      errors++; $display("FAIL llcrd_only: valid=%b sent=%b grant[2]=%b, expected 1/1/1",
                         obs_valid[1], obs_llc[1], obs_grant[2]);
    end
  endtask

  // Reset while CTRL is stalled; then the first tie must go to ack again.
  task automatic test_reset_in_ctrl();
    logic [63:0] rdy;
    logic [7:0]  outs;
    rdy = ONES;
    rdy[6] = 1'b0;
    for (int i = 0; i < NF; i++) exp_q.push_back(CF_FRAME);
    watch(7, rdy, ZERO, 64'h1, ZERO, ZERO);
    checks++;
    if (obs_valid[6] !== 1'b1 || obs_type[6] !== CF_RETRY_ACK || obs_ack[6] !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl_stall: valid=%b type=%0d sent=%b, expected 1/3/0",
                         obs_valid[6], obs_type[6], obs_ack[6]);
    end
    i_rst = 1'b1;
    bus.i_tx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      outs = {bus.o_flit_valid, bus.o_flit_type, bus.o_ack_sent, bus.o_req_sent,
              bus.o_llcrd_sent, bus.o_data_grant};
      checks++;
      if (outs !== 8'h00) begin
        errors++; $display("FAIL rst_ctrl_outputs[%0d]: got %h, expected 00", k, outs);
      end
      @(posedge i_clk); #1;
      bus.i_ack_req = 1'b0;
    end
    i_rst = 1'b0;
    bus.i_tx_ready = 1'b1;
    push_retry(CF_RETRY_ACK);
    push_retry(CF_RETRY_REQ);
    watch(16, ONES, ZERO, 64'h1, 64'h1, ZERO);
    checks++;
    if (obs_ack[6] !== 1'b1 || obs_req[13] !== 1'b1) begin
      errors++; $display("FAIL rst_tie_ack: ack_sent[6]=%b req_sent[13]=%b, expected 1/1",
                         obs_ack[6], obs_req[13]);
    end
  endtask

  initial begin
    test_reset();
    test_tie_ack_first();
    test_ack_only();
    test_tie_req_wins();
    test_stall();
    test_reinit();
    test_llcrd_wait();
    test_llcrd_only();
    test_reset_in_ctrl();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d flits never accepted, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
